al_dpram_wr_sched: RTL and testbench
====================================

// Module: al_dpram_wr_sched
// PURPOSE
//   Write scheduler for one LSLICE distributed RAM (MODE="RAMW", 16x4).
//   - Clears every RAM entry after reset or on request.
//   - Then shares the single write port among NREQ requesters by round-robin, one write per clk.
//   - Drives the slice's a[0..3]/b/c/d/e[0] write pins (waddr, di, we) from registers, so a slice's
//     dpram_waddr/dpram_di/dpram_we always see one-cycle-stable values.
// PARAMETERS
//   NREQ       4     number of requesters (2..8)
//   AW         4     RAM address width (depth = 2**AW)
//   DW         4     RAM data width
//   CLR_VALUE  4'h0  data written to every entry during clear
//   CLR_ON_RST 1     1: enter CLEAR after reset; 0: enter RUN directly, init_done=1
// PORTS
//   clk        in   1        clock; RAM write clock is the same net
//   srn        in   1        synchronous reset, active low
//   clr_req    in   1        pulse: re-clear the whole RAM
//   req_valid  in   NREQ     requester i has a write pending
//   req_addr   in   NREQ*AW  requester i address, slice i at [i*AW +: AW]
//   req_data   in   NREQ*DW  requester i data, slice i at [i*DW +: DW]
//   req_ready  out  NREQ     one-hot grant; a transfer happens when valid[i] & ready[i]
//   ram_we     out  1        registered write enable to slice
//   ram_waddr  out  AW       registered write address
//   ram_di     out  DW       registered write data
//   init_done  out  1        RAM contents valid (clear complete)
//   busy       out  1        high in CLEAR, or while ram_we is high
// BEHAVIOUR
//   Reset (srn=0 at a posedge):
//     - ram_we=0, ram_waddr=0, ram_di=0, req_ready=0.
//     - init_done=0 if CLR_ON_RST=1, else 1.
//     - rr pointer=0, clear counter=0.
//     - state=CLEAR if CLR_ON_RST=1, else RUN.
//   States: CLEAR, RUN.
//   CLEAR:
//     - req_ready=0.
//     - Each clk registers ram_we=1, ram_waddr=cnt, ram_di=CLR_VALUE, then cnt++.
//     - After the write of cnt=2**AW-1: cnt wraps to 0, state=RUN, init_done=1 (registered).
//     - Timing from the first clk with srn=1: waddr 0 appears in cycle 1, waddr 15 in cycle 16,
//       init_done=1 and first possible grant in cycle 17.
//   RUN:
//     - req_ready is combinational: one-hot to the first valid requester, searching upward
//       from the rr pointer and wrapping at NREQ-1 -> 0.
//     - No valid requester: req_ready=0.
//     - On transfer: next cycle ram_we=1, ram_waddr/ram_di = the granted requester's fields;
//       rr pointer = granted index + 1 mod NREQ.
//     - No transfer: ram_we=0 next cycle; ram_waddr/ram_di hold their values.
//     - Latency: request to RAM pins is 1 clk. Throughput is 1 write/clk.
//     - A requester holding valid is granted within NREQ cycles.
//   clr_req:
//     - In RUN, clr_req=1 forces req_ready=0 in that same cycle (clear wins over requests).
//       Next cycle: state=CLEAR, init_done=0, cnt=0.
//     - A write already registered on ram_* completes untouched.
//     - clr_req during CLEAR is ignored; the clear is not restarted.
//   Simultaneous writes: same address requested by two requesters -> served in grant order;
//     the last write wins.
//   Width: ram_waddr/ram_di are copied bit-exact, no arithmetic. cnt is AW+1 bits internally;
//     the MSB marks the wrap.
//   Mid-op srn=0 overrides everything within the same clk; the RAM is not guaranteed clear
//     until init_done=1 again.
// STRUCTURE
//   Package al_dpram_pkg:
//     - state enum (CLEAR=1'b0, RUN=1'b1)
//     - AW/DW defaults
//     - function first_set_from(ptr, vec)
//   Sub-module al_rr_arbiter #(NREQ):
//     - inputs: req vector, enable, ptr.
//     - outputs: one-hot grant, grant index.
//     - Purely combinational; the pointer register lives in the parent.
//   Parent holds state, cnt, rr pointer and the output registers.
// TESTING
//   1. Release srn -> ram_we=1 with waddr 0..15, di=0, cycles 1..16; init_done=1 at cycle 17;
//      req_ready=0 throughout.
//   2. RUN, all 4 valid held -> grants 0,1,2,3,0; ram_waddr follows one cycle later;
//      ram_we held at 1 for 5 cycles.
//   3. Only req2 valid (addr 4'h7, data 4'hA) -> req_ready=4'b0100; next clk ram_we=1,
//      ram_waddr=7, ram_di=A; pointer=3.
//   4. clr_req pulsed with req1 valid -> req_ready=0 that cycle; CLEAR rewrites 0..15;
//      req1 granted the cycle init_done rises.
//   5. srn=0 during CLEAR at cnt=9 -> outputs zero next clk; clear restarts at waddr 0.
//   6. CLR_ON_RST=0 -> init_done=1 and grant available in the first cycle after reset;
//      no clear writes issued.

Source files
------------

// File: rtl/al_dpram_pkg.sv
// Shared types and helpers for the distributed-RAM write scheduler.
package al_dpram_pkg;

    localparam int AW_DEF   = 4;
    localparam int DW_DEF   = 4;
    localparam int NREQ_MAX = 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Returns {found, index} of the first set bit at or after ptr, wrapping at n-1 -> 0.
    function automatic logic [3:0] first_set_from(input logic [2:0]          ptr,
                                                  input logic [NREQ_MAX-1:0] vec,
                                                  input int                  n);
        logic [3:0] res;
        int         j;
        res = '0;
        // Walk from the farthest offset down so the nearest hit is the one kept.
        for (int i = NREQ_MAX - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= n) j = j - n;
            if (i < n && vec[j[2:0]]) res = {1'b1, j[2:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/al_rr_arbiter.sv
// Combinational round-robin arbiter; the rotating pointer is owned by the parent.
module al_rr_arbiter
    import al_dpram_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   gnt_idx_o
);

    logic [NREQ_MAX-1:0] vec;
    logic [2:0]          ptr;
    logic [3:0]          res;

    always_comb begin
        vec             = '0;
        vec[NREQ-1:0]   = req_i;
        ptr             = '0;
        ptr[PW-1:0]     = ptr_i;
        res             = first_set_from(ptr, vec, NREQ);
        gnt_idx_o       = PW'(res[2:0]);
        gnt_o           = (en_i && res[3]) ? (NREQ'(1) << res[2:0]) : '0;
    end

endmodule

// File: rtl/al_dpram_wr_sched.sv
// Write scheduler for one 16x4 distributed RAM: clears the array, then
// round-robins the single registered write port among NREQ requesters.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_CLEAR | writing CLR_VALUE to every address; no grants
//   ST_RUN   | RAM valid; one round-robin grant per clk onto the write pins
module al_dpram_wr_sched
    import al_dpram_pkg::*;
#(
    parameter int            NREQ       = 4,
    parameter int            AW         = AW_DEF,
    parameter int            DW         = DW_DEF,
    parameter logic [DW-1:0] CLR_VALUE  = '0,
    parameter bit            CLR_ON_RST = 1'b1
) (
    input  logic               clk_i,
    input  logic               srn_i,
    input  logic               clr_req_i,
    input  logic [NREQ-1:0]    req_valid_i,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ*DW-1:0] req_data_i,
    output logic [NREQ-1:0]    req_ready_o,
    output logic               ram_we_o,
    output logic [AW-1:0]      ram_waddr_o,
    output logic [DW-1:0]      ram_di_o,
    output logic               init_done_o,
    output logic               busy_o
);

    localparam int PW = $clog2(NREQ);

    state_e          state_q, state_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            we_q, we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [DW-1:0]   di_q, di_d;
    logic            done_q, done_d;

    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gnt_idx;
    logic            arb_en;

    // A clear request beats any pending write in the same cycle.
    assign arb_en = (state_q == ST_RUN) && !clr_req_i;

    al_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req_i     (req_valid_i),
        .en_i      (arb_en),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign req_ready_o = gnt;
    assign ram_we_o    = we_q;
    assign ram_waddr_o = waddr_q;
    assign ram_di_o    = di_q;
    assign init_done_o = done_q;
    assign busy_o      = (state_q == ST_CLEAR) || we_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        di_d    = di_q;
        done_d  = done_q;
        case (state_q)
            ST_CLEAR: begin
                // MSB set means the last address has already been written.
                if (cnt_q[AW]) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = cnt_q[AW-1:0];
                    di_d    = CLR_VALUE;
                    cnt_d   = cnt_q + {{AW{1'b0}}, 1'b1};
                end
            end
            ST_RUN: begin
                if (clr_req_i) begin
                    state_d = ST_CLEAR;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                end else if (|gnt) begin
                    we_d    = 1'b1;
                    waddr_d = req_addr_i[int'(gnt_idx)*AW +: AW];
                    di_d    = req_data_i[int'(gnt_idx)*DW +: DW];
                    ptr_d   = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!srn_i) begin
            state_q <= CLR_ON_RST ? ST_CLEAR : ST_RUN;
            cnt_q   <= '0;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            di_q    <= '0;
            done_q  <= ~CLR_ON_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            di_q    <= di_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_al_dpram_wr_sched.sv
// Bench for al_dpram_wr_sched: directed scenarios plus random traffic,
// checked against a cycle-level behavioural model and a shadow RAM.
module tb_al_dpram_wr_sched;

    logic        clk_i = 1'b0;
    logic        srn_i;
    logic        clr_req_i;
    logic [3:0]  req_valid_i;
    logic [15:0] req_addr_i;
    logic [15:0] req_data_i;

    logic [3:0]  rdy_a, rdy_b;
    logic        we_a, we_b, done_a, done_b, busy_a, busy_b;
    logic [3:0]  waddr_a, waddr_b, di_a, di_b;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    al_dpram_wr_sched #(.NREQ(4), .AW(4), .DW(4), .CLR_VALUE(4'h0), .CLR_ON_RST(1'b1)) u_dut (
        .clk_i(clk_i), .srn_i(srn_i), .clr_req_i(clr_req_i),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .req_ready_o(rdy_a), .ram_we_o(we_a), .ram_waddr_o(waddr_a), .ram_di_o(di_a),
        .init_done_o(done_a), .busy_o(busy_a)
    );

    al_dpram_wr_sched #(.NREQ(4), .AW(4), .DW(4), .CLR_VALUE(4'h0), .CLR_ON_RST(1'b0)) u_dut_norst (
        .clk_i(clk_i), .srn_i(srn_i), .clr_req_i(clr_req_i),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .req_ready_o(rdy_b), .ram_we_o(we_b), .ram_waddr_o(waddr_b), .ram_di_o(di_b),
        .init_done_o(done_b), .busy_o(busy_b)
    );

    // Reference model state (CLR_ON_RST=1 instance)
    bit         m_clearing;
    int         m_clr_idx;
    int         m_ptr;
    bit         m_done;
    bit         m_we;
    logic [3:0] m_waddr, m_di;
    logic [3:0] ram_ref [16];
    logic [3:0] ram_obs [16];
    logic [3:0] last_rdy;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        m_clearing = 1'b1;
        m_clr_idx  = 0;
        m_ptr      = 0;
        m_done     = 1'b0;
        m_we       = 1'b0;
        m_waddr    = 4'h0;
        m_di       = 4'h0;
    endtask

    // One clock: check the combinational grant, advance the model, check registered pins.
    task automatic step();
        int g;
        logic [3:0] exp_rdy;
        #1;
        g = -1;
        if (!m_clearing && !clr_req_i) begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (m_ptr + k) % 4;
                if (g < 0 && req_valid_i[idx]) g = idx;
            end
        end
        exp_rdy  = (g >= 0) ? 4'(1 << g) : 4'h0;
        last_rdy = rdy_a;
        chk_eq("req_ready", 32'(rdy_a), 32'(exp_rdy));

        if (!srn_i) begin
            mdl_reset();
        end else if (m_clearing) begin
            if (m_clr_idx < 16) begin
                m_we    = 1'b1;
                m_waddr = 4'(m_clr_idx);
                m_di    = 4'h0;
                ram_ref[m_clr_idx] = 4'h0;
                m_clr_idx++;
            end else begin
                m_we       = 1'b0;
                m_clearing = 1'b0;
                m_done     = 1'b1;
                m_clr_idx  = 0;
            end
        end else if (clr_req_i) begin
            m_we       = 1'b0;
            m_clearing = 1'b1;
            m_clr_idx  = 0;
            m_done     = 1'b0;
        end else if (g >= 0) begin
            m_we    = 1'b1;
            m_waddr = req_addr_i[g*4 +: 4];
            m_di    = req_data_i[g*4 +: 4];
            m_ptr   = (g + 1) % 4;
            ram_ref[m_waddr] = m_di;
        end else begin
            m_we = 1'b0;
        end

        @(posedge clk_i);
        #1;
        chk_eq("ram_we",    32'(we_a),    32'(m_we));
        chk_eq("ram_waddr", 32'(waddr_a), 32'(m_waddr));
        chk_eq("ram_di",    32'(di_a),    32'(m_di));
        chk_eq("init_done", 32'(done_a),  32'(m_done));
        chk_eq("busy",      32'(busy_a),  32'(m_clearing || m_we));
        if (we_a) ram_obs[waddr_a] = di_a;
    endtask

    task automatic rand_req();
        req_valid_i = 4'($urandom_range(0, 15));
        req_addr_i  = 16'($urandom) & 16'h7777;
        req_data_i  = 16'($urandom);
    endtask

    initial begin
        srn_i = 1'b0; clr_req_i = 1'b0;
        req_valid_i = '0; req_addr_i = '0; req_data_i = '0;
        for (int a = 0; a < 16; a++) begin
            ram_ref[a] = 4'h0;
            ram_obs[a] = 4'h0;
        end
        repeat (3) @(posedge clk_i);
        #1;
        mdl_reset();

        // Release reset; the no-clear instance must grant immediately.
        srn_i       = 1'b1;
        req_valid_i = 4'b0010;
        req_addr_i  = 16'h0030;
        req_data_i  = 16'h0060;
        #1;
        chk_eq("norst_ready", 32'(rdy_b),  32'h2);
        chk_eq("norst_done",  32'(done_b), 32'h1);
        chk_eq("norst_busy",  32'(busy_b), 32'h0);
        chk_eq("norst_we0",   32'(we_b),   32'h0);
        step();
        chk_eq("clr_first",   32'(waddr_a), 32'h0);
        chk_eq("norst_we1",   32'(we_b),    32'h1);
        chk_eq("norst_waddr", 32'(waddr_b), 32'h3);
        chk_eq("norst_di",    32'(di_b),    32'h6);

        // Rest of the power-up clear with random traffic and ignored clear requests.
        for (int c = 2; c <= 17; c++) begin
            rand_req();
            clr_req_i = ($urandom_range(0, 3) == 0);
            step();
            if (c == 16) begin
                chk_eq("clr_last",  32'(waddr_a), 32'hf);
                chk_eq("clr_nodone", 32'(done_a), 32'h0);
            end
            if (c == 17) chk_eq("done_rise", 32'(done_a), 32'h1);
        end
        clr_req_i = 1'b0;

        // All requesters valid: strict rotation 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            req_valid_i = 4'hf;
            req_addr_i  = 16'($urandom);
            req_data_i  = 16'($urandom);
            step();
            chk_eq("rr_seq",  32'(last_rdy), 32'(1 << (k % 4)));
            chk_eq("rr_we",   32'(we_a),     32'h1);
        end

        // Lone requester 2.
        req_valid_i = 4'b0100;
        req_addr_i  = 16'h0700;
        req_data_i  = 16'h0a00;
        step();
        chk_eq("solo_rdy",   32'(last_rdy), 32'h4);
        chk_eq("solo_waddr", 32'(waddr_a),  32'h7);
        chk_eq("solo_di",    32'(di_a),     32'ha);

        // Pointer now 3; both 3 and 0 hit address 5, requester 0 is last and wins.
        req_valid_i = 4'b1001;
        req_addr_i  = 16'h5005;
        req_data_i  = 16'h9001;
        step();
        chk_eq("ptr_after2", 32'(last_rdy), 32'h8);
        step();
        chk_eq("wrap_to0",   32'(last_rdy), 32'h1);
        chk_eq("last_wins",  32'(ram_obs[5]), 32'h1);
        req_valid_i = '0;
        step();

        // Clear request beats a pending requester; it is served as init_done rises.
        req_valid_i = 4'b0010;
        req_addr_i  = 16'h00c0;
        req_data_i  = 16'h00d0;
        clr_req_i   = 1'b1;
        step();
        chk_eq("clr_blocks", 32'(last_rdy), 32'h0);
        clr_req_i = 1'b0;
        repeat (17) step();
        chk_eq("reclr_done", 32'(done_a), 32'h1);
        step();
        chk_eq("post_clr_gnt", 32'(last_rdy), 32'h2);
        chk_eq("post_clr_wa",  32'(waddr_a),  32'hc);

        // Reset in the middle of a clear restarts it from address 0.
        req_valid_i = '0;
        clr_req_i   = 1'b1;
        step();
        clr_req_i = 1'b0;
        repeat (9) step();
        chk_eq("mid_clr_wa", 32'(waddr_a), 32'h8);
        srn_i = 1'b0;
        step();
        chk_eq("rst_we",    32'(we_a),    32'h0);
        chk_eq("rst_waddr", 32'(waddr_a), 32'h0);
        chk_eq("rst_done",  32'(done_a),  32'h0);
        srn_i = 1'b1;
        step();
        chk_eq("restart_wa", 32'(waddr_a), 32'h0);
        chk_eq("restart_we", 32'(we_a),    32'h1);
        repeat (16) step();
        chk_eq("restart_done", 32'(done_a), 32'h1);

        // Random traffic with occasional clear and reset.
        repeat (400) begin
            rand_req();
            clr_req_i = ($urandom_range(0, 39) == 0);
            srn_i     = ($urandom_range(0, 149) != 0);
            step();
        end

        srn_i = 1'b1; clr_req_i = 1'b0; req_valid_i = '0;
        repeat (20) step();
        for (int a = 0; a < 16; a++) chk_eq("ram_content", 32'(ram_obs[a]), 32'(ram_ref[a]));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
